// File: rtl/dac_pkg.sv
// dac_pkg: shared state encoding, default widths and idle code for the DAC player
package dac_pkg;
    typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam logic [7:0] IDLE_CODE = 8'd128;
endpackage

// File: rtl/dac_playback_if.sv
// dac_playback_if: buffer write port, playback control and DAC output bundle
interface dac_playback_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] len;
    logic              loop;
    logic [7:0]        div;
    logic              test_ramp;
    logic [DATA_W-1:0] da_data;
    logic              sample_stb;
    logic              busy;
    logic              done;
    modport master (
        output wr_en, wr_addr, wr_data, start, stop, len, loop, div, test_ramp,
        input  da_data, sample_stb, busy, done
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, len, loop, div, test_ramp,
        output da_data, sample_stb, busy, done
    );
endinterface

// File: rtl/dac_sample_ram.sv
// dac_sample_ram: simple dual-port sample buffer, synchronous read-before-write
module dac_sample_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk_35M,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk_35M) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/dac_playback.sv
// dac_playback: buffered DAC sample player; DAC_PLAYBACK_RAMP_EN adds a free-running ramp test mode
module dac_playback
    import dac_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter logic [DATA_W-1:0] IDLE_CODE = DATA_W'(dac_pkg::IDLE_CODE)
) (
    input logic clk_35M,
    input logic rst,
    dac_playback_if.slave bus
);
    state_t            state;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] nxt;
    logic [ADDR_W-1:0] succ;
    logic [ADDR_W-1:0] raddr;
    logic [7:0]        div_q;
    logic [7:0]        cnt;
    logic              loop_q;
    logic              stop_q;
    logic              first;
    logic              last;
    logic              bnd;
    logic              fin;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] smp;
    // nxt is the index shown at the next boundary; on a boundary the RAM already fetches the one after it
    assign bnd   = state == PLAY && cnt == '0;
    assign succ  = nxt == len_q ? '0 : nxt + 1'b1;
    assign raddr = bnd ? succ : nxt;
`ifdef DAC_PLAYBACK_RAMP_EN
    logic              ramp_q;
    logic [DATA_W-1:0] ramp_v;
    assign smp = ramp_q ? ramp_v : rd_data;
    assign fin = !ramp_q && !loop_q && nxt == len_q;
`else
    assign smp = rd_data;
    assign fin = !loop_q && nxt == len_q;
`endif
    dac_sample_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk_35M(clk_35M),
        .wr_en(bus.wr_en),
        .wr_addr(bus.wr_addr),
        .wr_data(bus.wr_data),
        .rd_addr(raddr),
        .rd_data(rd_data)
    );
    always_ff @(posedge clk_35M or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bus.da_data    <= IDLE_CODE;
            bus.sample_stb <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            len_q          <= '0;
            div_q          <= '0;
            loop_q         <= 1'b0;
            cnt            <= '0;
            nxt            <= '0;
            stop_q         <= 1'b0;
            first          <= 1'b0;
            last           <= 1'b0;
`ifdef DAC_PLAYBACK_RAMP_EN
            ramp_q         <= 1'b0;
            ramp_v         <= '0;
`endif
        end else begin
            bus.sample_stb <= 1'b0;
            bus.done       <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state    <= PRIME;
                    bus.busy <= 1'b1;
                    len_q    <= bus.len;
                    div_q    <= bus.div;
                    loop_q   <= bus.loop;
                    cnt      <= '0;
                    nxt      <= '0;
                    stop_q   <= 1'b0;
                    first    <= 1'b1;
                    last     <= 1'b0;
`ifdef DAC_PLAYBACK_RAMP_EN
                    ramp_q   <= bus.test_ramp;
                    ramp_v   <= '0;
`endif
                end
                PRIME: begin
                    state  <= PLAY;
                    stop_q <= bus.stop;
                end
                PLAY: begin
                    if (bus.stop) stop_q <= 1'b1;
                    if (!bnd) cnt <= cnt - 1'b1;
                    else if (!first && (last || stop_q)) begin
                        state       <= IDLE;
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                        bus.da_data <= IDLE_CODE;
                    end else begin
                        bus.da_data    <= smp;
                        bus.sample_stb <= 1'b1;
                        cnt            <= div_q;
                        nxt            <= succ;
                        first          <= 1'b0;
                        last           <= fin;
`ifdef DAC_PLAYBACK_RAMP_EN
                        ramp_v         <= ramp_v + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dac_playback.sv
// tb_dac_playback: table-driven and randomized playback checks against a cycle-timeline model
module tb_dac_playback;
    logic clk_35M = 1'b0;
    logic rst = 1'b1;
    always #5 clk_35M = ~clk_35M;
    dac_playback_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    dac_playback #(.ADDR_W(8), .DATA_W(8), .IDLE_CODE(8'h80)) dut (
        .clk_35M(clk_35M),
        .rst(rst),
        .bus(bus)
    );
`ifdef DAC_PLAYBACK_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif
    localparam int RAMP_DONE = RAMP_EN ? 259 : 6;
    localparam int RAMP_NSTB = RAMP_EN ? 257 : 4;
    typedef struct {
        string nm;
        int    len;
        int    div;
        bit    loop;
        bit    ramp;
        int    ts;
        int    rs;
        int    done_t;
        int    nstb;
    } vec_t;
    vec_t vecs[$];
    logic [7:0] mem [256];
    int checks = 0;
    int errors = 0;
    task automatic chk(input string nm, input int t, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s t=%0d got %0h exp %0h", nm, t, got, exp);
        end
    endtask
    task automatic wr(input int a, input int d);
        bus.wr_en = 1'b1;
        bus.wr_addr = 8'(a);
        bus.wr_data = 8'(d);
        @(posedge clk_35M);
        mem[a] = 8'(d);
        @(negedge clk_35M);
        bus.wr_en = 1'b0;
    endtask
    // Timeline model: t counts edges after the start edge; sample k occupies [2+k*p, 2+(k+1)*p)
    task automatic run(input string nm, input int len, input int div, input bit loop, input bit ramp,
                       input int ts, input int rs, input bit wrs, output int done_t, output int nstb);
        int p = div + 1;
        int n = len + 1;
        int ms = 1 << 30;
        int m_end, end_t, k, e_da, e_stb, e_busy, e_done;
        bit rmp = ramp && RAMP_EN;
        if (ts > 0) begin
            ms = 1;
            while (2 + ms * p <= ts) ms++;
        end
        m_end = (loop || rmp) ? ms : (n < ms ? n : ms);
        end_t = 2 + m_end * p;
        done_t = -1;
        nstb = 0;
        bus.len = 8'(len);
        bus.div = 8'(div);
        bus.loop = loop;
        bus.test_ramp = ramp;
        bus.start = 1'b1;
        bus.stop = (ts == 0);
        @(posedge clk_35M);
        for (int t = 0; t <= end_t + 1; t++) begin
            @(negedge clk_35M);
            if (bus.wr_en) mem[bus.wr_addr] = bus.wr_data;
            if (t < 2) begin
                e_da = 8'h80; e_stb = 0; e_busy = 1; e_done = 0;
            end else if (t < end_t) begin
                k = (t - 2) / p;
                e_da = rmp ? k % 256 : int'(mem[k % n]);
                e_stb = ((t - 2) % p == 0) ? 1 : 0;
                e_busy = 1; e_done = 0;
            end else begin
                e_da = 8'h80; e_stb = 0; e_busy = 0; e_done = (t == end_t) ? 1 : 0;
            end
            chk({nm, ".da"}, t, int'(bus.da_data), e_da);
            chk({nm, ".stb"}, t, int'(bus.sample_stb), e_stb);
            chk({nm, ".busy"}, t, int'(bus.busy), e_busy);
            chk({nm, ".done"}, t, int'(bus.done), e_done);
            if (bus.done && done_t < 0) done_t = t;
            nstb += int'(bus.sample_stb);
            bus.start = (t + 1 == rs);
            bus.stop = (t + 1 == ts);
            bus.len = 8'($urandom);
            bus.div = 8'($urandom_range(0, 3));
            bus.loop = 1'($urandom);
            bus.test_ramp = 1'($urandom);
            bus.wr_en = wrs && 1'($urandom);
            bus.wr_addr = 8'($urandom_range(240, 255));
            bus.wr_data = 8'($urandom);
        end
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.wr_en = 1'b0;
    endtask
    initial begin
        int dt, ns;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.len = '0; bus.loop = 1'b0;
        bus.div = '0; bus.test_ramp = 1'b0;
        vecs.push_back('{"r020", 3, 0, 1'b0, 1'b0, -1, -1, 6, 4});
        vecs.push_back('{"r021", 3, 2, 1'b1, 1'b0, 6, -1, 8, 2});
        vecs.push_back('{"wrap", 3, 2, 1'b1, 1'b0, 16, -1, 17, 5});
        vecs.push_back('{"r022", 0, 0, 1'b0, 1'b0, -1, 2, 3, 1});
        vecs.push_back('{"r010", 2, 1, 1'b0, 1'b0, 0, -1, 8, 3});
        vecs.push_back('{"hold", 1, 4, 1'b0, 1'b0, -1, -1, 12, 2});
        vecs.push_back('{"ramp", 3, 0, 1'b0, 1'b1, 258, -1, RAMP_DONE, RAMP_NSTB});
        repeat (3) @(posedge clk_35M);
        #1;
        chk("rst.da", 0, int'(bus.da_data), 8'h80);
        chk("rst.stb", 0, int'(bus.sample_stb), 0);
        chk("rst.busy", 0, int'(bus.busy), 0);
        chk("rst.done", 0, int'(bus.done), 0);
        @(negedge clk_35M);
        rst = 1'b0;
        for (int a = 0; a < 256; a++) wr(a, a ^ 8'h5a);
        for (int a = 0; a < 4; a++) wr(a, 8'h10 + a);
        foreach (vecs[i]) begin
            run(vecs[i].nm, vecs[i].len, vecs[i].div, vecs[i].loop, vecs[i].ramp,
                vecs[i].ts, vecs[i].rs, 1'b0, dt, ns);
            chk({vecs[i].nm, ".done_t"}, 0, dt, vecs[i].done_t);
            chk({vecs[i].nm, ".nstb"}, 0, ns, vecs[i].nstb);
        end
        bus.len = 8'd3; bus.div = 8'd5; bus.loop = 1'b1; bus.test_ramp = 1'b0; bus.start = 1'b1;
        @(posedge clk_35M);
        @(negedge clk_35M);
        bus.start = 1'b0;
        repeat (6) @(posedge clk_35M);
        #2 rst = 1'b1;
        #1;
        chk("r023.da", 0, int'(bus.da_data), 8'h80);
        chk("r023.busy", 0, int'(bus.busy), 0);
        chk("r023.stb", 0, int'(bus.sample_stb), 0);
        @(negedge clk_35M);
        rst = 1'b0;
        run("r023", 3, 0, 1'b0, 1'b0, -1, -1, 1'b0, dt, ns);
        chk("r023.done_t", 0, dt, 6);
        for (int i = 0; i < 6; i++) begin
            int len = $urandom_range(0, 15);
            int div = $urandom_range(0, 3);
            bit lp = 1'($urandom);
            int ts = lp ? $urandom_range(1, 60) : ($urandom_range(0, 1) == 1 ? $urandom_range(1, 40) : -1);
            for (int a = 0; a <= len; a++) wr(a, $urandom);
            run("rand", len, div, lp, 1'b0, ts, -1, 1'b1, dt, ns);
        end
        run("full", 255, 0, 1'b0, 1'b0, -1, -1, 1'b0, dt, ns);
        chk("full.done_t", 0, dt, 258);
        chk("full.nstb", 0, ns, 256);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
